pio_gpio_core: RTL and testbench
================================

Name: pio_gpio_core

Overview:
Parametrised Avalon-MM general-purpose I/O block for the SoC. It is the next generation of the fixed 14-bit output-only LED PIO.
- Configurable width.
- Per-bit direction register.
- Atomic bit set/clear registers.
- Synchronised input sampling with edge capture.
- Maskable level interrupt to the CPU.
- Zero-wait-state slave on the system clock.

Parameters:
DATA_WIDTH, 14, port width in bits; legal range 1..32
RESET_VALUE, 0, data_out value after reset (DATA_WIDTH bits)
DIR_RESET, 0, direction register after reset; 1 = output, per bit
EDGE_TYPE, 0, captured edge: 0 = rising, 1 = falling, 2 = any
SYNC_STAGES, 2, input synchroniser depth; legal range 2..3

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above DATA_WIDTH ignored
readdata  out  32  read data, zero-extended above DATA_WIDTH
in_port  in  DATA_WIDTH  asynchronous pin inputs
out_port  out  DATA_WIDTH  data_out value
oe_port  out  DATA_WIDTH  output enable = direction register
irq  out  1  interrupt request, active high

Behaviour:
- Reset (async, high): data_out=RESET_VALUE, dir=DIR_RESET, irq_mask=0, edge_cap=0, sync/prev regs=0, arm counter=0. Outputs: out_port=RESET_VALUE, oe_port=DIR_RESET, irq=0, readdata=0 while chipselect=0.
- Register map (word addresses):
  - 0 DATA: R = (sync_in & ~dir) | (data_out & dir); W sets data_out.
  - 1 DIR: R/W.
  - 2 IRQ_MASK: R/W.
  - 3 EDGE_CAP: R; W1C.
  - 4 OUTSET: W only; data_out |= wdata.
  - 5 OUTCLR: W only; data_out &= ~wdata.
  - 4, 5, 6 and 7 read as 0. Writes to 6 and 7 are ignored.
- Write strobe = chipselect & ~write_n. All registers update on the next rising clk edge.
- Read: readdata is combinational from address; zero wait states, zero latency; readdata=0 when chipselect=0.
- Input path: SYNC_STAGES flop chain into sync_in, then prev = sync_in delayed one clock.
- Edge detect, per bit:
  - rise = sync_in & ~prev
  - fall = ~sync_in & prev
  - EDGE_TYPE selects rise, fall, or rise|fall.
  - Capture applies to all bits regardless of dir.
- Arming: a saturating counter counts SYNC_STAGES+1 clocks after reset. Edge capture is suppressed until it saturates, so a pin held high through reset does not produce a spurious capture.
- Latency: pin transition to edge_cap bit set = SYNC_STAGES+1 clocks. edge_cap to irq = combinational.
- irq = |(edge_cap & irq_mask).
- Simultaneous W1C and new edge on the same bit: set wins; the bit stays 1.
- Captured bits stay set until cleared. Repeated edges have no further effect.
- Masking a pending bit drops irq immediately; edge_cap is unchanged. Unmasking re-asserts irq.
- Reset mid-operation clears all state asynchronously and re-arms the counter from 0.

Decomposition:
- Package pio_gpio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLR
  - edge-type constants EDGE_RISE, EDGE_FALL, EDGE_ANY
- Sub-module pio_sync_edge (parametrised by DATA_WIDTH, SYNC_STAGES, EDGE_TYPE) contains the synchroniser, prev register, arm counter and edge pulse output.
- The top level holds the registers, read mux and irq.

Test Plan:
- Reset with RESET_VALUE=0x2A5, DIR_RESET=0x3FFF -> out_port=0x2A5, oe_port=0x3FFF, irq=0; read addr 0 returns 0x000002A5.
- Write 0x0F0 to addr 0, then 0x003 to addr 4, then 0x030 to addr 5 -> out_port=0x0C3 after the third write; read addr 0 returns 0x0C3 with dir all-ones.
- dir=0, EDGE_TYPE=0, mask=0x001; drive in_port[0] 0->1 -> edge_cap=0x001 and irq=1 exactly 3 clocks later; write 0x001 to addr 3 -> irq=0 next clock.
- Hold in_port=0x3FFF through reset release -> edge_cap stays 0 for 100 clocks.
- EDGE_TYPE=2: pulse in_port[5] high for 4 clocks -> edge_cap[5] set; W1C issued in the same cycle as the falling-edge capture -> bit remains 1.
- Write 0xFFFFFFFF to addr 2 -> read addr 2 returns 0x00003FFF; read addr 6 returns 0; assert reset mid-stream -> all registers return to reset values the same cycle.

Source files
------------

// File: rtl/pio_gpio_pkg.sv
// Shared constants for the parametrised GPIO PIO: register word addresses and edge-type selectors.
package pio_gpio_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned BUS_W    = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR   = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, one-clock history register and post-reset arming for per-bit edge detection.
module pio_sync_edge
    import pio_gpio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pins,
    output logic [DATA_WIDTH-1:0] sync_in,
    output logic [DATA_WIDTH-1:0] edge_hit_c
);

    localparam int unsigned ARM_COUNT = SYNC_STAGES + 1;
    localparam int unsigned CNT_W     = $clog2(ARM_COUNT + 1);

    logic [DATA_WIDTH-1:0] chain [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev;
    logic [CNT_W-1:0]      arm_cnt;
    logic                  armed;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] fall;
    logic [DATA_WIDTH-1:0] detect;

    // Metastability chain followed by the history register used for edge comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= pins;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    // Holds off capture until the chain has flushed, so pins held high through reset stay quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (arm_cnt != CNT_W'(ARM_COUNT)) begin
            arm_cnt <= arm_cnt + CNT_W'(1);
        end
    end

    assign armed   = (arm_cnt == CNT_W'(ARM_COUNT));
    assign sync_in = chain[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev;
    assign fall    = ~sync_in & prev;

    always_comb begin
        detect = rise;
        if (EDGE_TYPE == EDGE_FALL) begin
            detect = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            detect = rise | fall;
        end
    end

    assign edge_hit_c = detect & {DATA_WIDTH{armed}};

endmodule

// File: rtl/pio_gpio_core.sv
// Avalon-MM GPIO slave: data/direction/mask registers, atomic set/clear, W1C edge capture and level irq.
module pio_gpio_core
    import pio_gpio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 14,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [BUS_W-1:0]      writedata,
    output logic [BUS_W-1:0]      readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] dir;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edge_cap;
    logic [DATA_WIDTH-1:0] edge_cap_next;
    logic [DATA_WIDTH-1:0] edge_clr;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr;

    pio_sync_edge #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .rst        (reset),
        .pins       (in_port),
        .sync_in    (sync_in),
        .edge_hit_c (edge_hit)
    );

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[DATA_WIDTH-1:0];

    // Upper bus bits have no register behind them when the port is narrower than the bus
    if (DATA_WIDTH < BUS_W) begin : g_narrow
        logic unused_wdata;
        assign unused_wdata = ^writedata[BUS_W-1:DATA_WIDTH];
    end

    // A fresh edge beats a simultaneous W1C on the same bit
    always_comb begin
        edge_clr = '0;
        if (wr && (address == ADDR_EDGE_CAP)) begin
            edge_clr = wdata;
        end
        edge_cap_next = (edge_cap & ~edge_clr) | edge_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE;
            dir      <= DIR_RESET;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:     data_out <= wdata;
                    ADDR_DIR:      dir      <= wdata;
                    ADDR_IRQ_MASK: irq_mask <= wdata;
                    ADDR_OUTSET:   data_out <= data_out | wdata;
                    ADDR_OUTCLR:   data_out <= data_out & ~wdata;
                    default:       ;
                endcase
            end
            edge_cap <= edge_cap_next;
        end
    end

    // Zero-latency read mux; output pins read back their driven value, inputs their synchronised value
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA:     rd_word = (sync_in & ~dir) | (data_out & dir);
            ADDR_DIR:      rd_word = dir;
            ADDR_IRQ_MASK: rd_word = irq_mask;
            ADDR_EDGE_CAP: rd_word = edge_cap;
            default:       rd_word = '0;
        endcase
    end

    assign readdata = chipselect ? BUS_W'(rd_word) : '0;
    assign out_port = data_out;
    assign oe_port  = dir;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_gpio_core.sv
// Self-checking bench: two GPIO instances (rising / any edge) against a pin-history reference model.
module tb_pio_gpio_core;
    import pio_gpio_pkg::*;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [13:0] in_port;

    logic [31:0] rd_r, rd_a;
    logic [13:0] out_r, out_a, oe_r, oe_a;
    logic        irq_r, irq_a;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pio_gpio_core #(.DATA_WIDTH(14), .RESET_VALUE(14'h2A5), .DIR_RESET(14'h3FFF),
                    .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(S)) dut_r (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r),
        .in_port(in_port), .out_port(out_r), .oe_port(oe_r), .irq(irq_r));

    pio_gpio_core #(.DATA_WIDTH(14), .RESET_VALUE(14'h2A5), .DIR_RESET(14'h3FFF),
                    .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port), .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

    // Reference model: index 0 = rising-edge instance, 1 = any-edge instance
    logic [13:0] m_out [2];
    logic [13:0] m_dir [2];
    logic [13:0] m_mask[2];
    logic [13:0] m_cap [2];
    logic [13:0] hist  [4];   // hist[k] = pin value sampled k+1 edges ago
    int          since_rst;
    int          m_et  [2] = '{0, 2};

    function automatic logic [13:0] edges_of(input int et, input logic [13:0] s, input logic [13:0] p);
        case (et)
            0:       return s & ~p;
            1:       return ~s & p;
            default: return s ^ p;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input int k);
        logic [13:0] v;
        v = '0;
        if (chipselect) begin
            case (address)
                3'd0:    v = (hist[S-1] & ~m_dir[k]) | (m_out[k] & m_dir[k]);
                3'd1:    v = m_dir[k];
                3'd2:    v = m_mask[k];
                3'd3:    v = m_cap[k];
                default: v = '0;
            endcase
        end
        return 32'(v);
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic [13:0] det;
        logic [13:0] wd;
        logic        we;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_out[k] = 14'h2A5; m_dir[k] = 14'h3FFF; m_mask[k] = '0; m_cap[k] = '0;
            end
            for (int i = 0; i < 4; i++) hist[i] = '0;
            since_rst = 0;
        end else begin
            wd = writedata[13:0];
            we = chipselect && !write_n;
            for (int k = 0; k < 2; k++) begin
                det = (since_rst >= S + 1) ? edges_of(m_et[k], hist[S-1], hist[S]) : 14'h0;
                if (we && address == 3'd3) m_cap[k] = (m_cap[k] & ~wd) | det;
                else                       m_cap[k] = m_cap[k] | det;
                if (we) begin
                    case (address)
                        3'd0: m_out[k]  = wd;
                        3'd1: m_dir[k]  = wd;
                        3'd2: m_mask[k] = wd;
                        3'd4: m_out[k]  = m_out[k] | wd;
                        3'd5: m_out[k]  = m_out[k] & ~wd;
                        default: ;
                    endcase
                end
            end
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = in_port;
            if (since_rst < S + 1) since_rst++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("out_r", 32'(out_r), 32'(m_out[0]));
        check("out_a", 32'(out_a), 32'(m_out[1]));
        check("oe_r",  32'(oe_r),  32'(m_dir[0]));
        check("oe_a",  32'(oe_a),  32'(m_dir[1]));
        check("irq_r", 32'(irq_r), 32'(|(m_cap[0] & m_mask[0])));
        check("irq_a", 32'(irq_a), 32'(|(m_cap[1] & m_mask[1])));
        check("rd_r",  rd_r, m_read(0));
        check("rd_a",  rd_a, m_read(1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a,
                          input logic [31:0] exp_r, input logic [31:0] exp_a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        check({name, "_r"}, rd_r, exp_r);
        check({name, "_a"}, rd_a, exp_a);
        chipselect = 1'b0;
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        tick(); tick();
        check("rst_out",  32'(out_r), 32'h2A5);
        check("rst_oe",   32'(oe_r),  32'h3FFF);
        check("rst_irq",  32'(irq_r), 32'h0);
        check("rst_rd_cs0", rd_r, 32'h0);
        reset = 1'b0;
        rd_chk("rst_data", 3'd0, 32'h2A5, 32'h2A5);

        // Direct write, atomic set, atomic clear
        wr(3'd0, 32'h0F0);
        wr(3'd4, 32'h003);
        wr(3'd5, 32'h030);
        check("setclr_out", 32'(out_r), 32'h0C3);
        rd_chk("setclr_data", 3'd0, 32'h0C3, 32'h0C3);

        // Rising edge on bit 0: three clocks to capture, W1C drops irq next clock
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h1);
        in_port = 14'h001;
        tick(); tick();
        check("lat_irq_early", 32'(irq_r), 32'h0);
        tick();
        check("lat_irq_r", 32'(irq_r), 32'h1);
        check("lat_irq_a", 32'(irq_a), 32'h1);
        rd_chk("lat_cap", 3'd3, 32'h1, 32'h1);
        wr(3'd3, 32'h1);
        check("w1c_irq_r", 32'(irq_r), 32'h0);
        check("w1c_irq_a", 32'(irq_a), 32'h0);

        // Pins held high through reset release must not capture
        in_port = 14'h3FFF;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        address = 3'd3; chipselect = 1'b1; write_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            check("arm_cap_r", rd_r, 32'h0);
            check("arm_cap_a", rd_a, 32'h0);
            tick();
        end
        chipselect = 1'b0;

        // Any-edge: W1C coincident with the falling-edge capture loses
        in_port = '0;
        repeat (5) tick();
        wr(3'd3, 32'h3FFF);
        rd_chk("pre_pulse_cap", 3'd3, 32'h0, 32'h0);
        in_port = 14'h020;
        tick(); tick(); tick();
        rd_chk("pulse_rise_cap", 3'd3, 32'h20, 32'h20);
        wr(3'd3, 32'h20);
        in_port = '0;
        tick(); tick();
        wr(3'd3, 32'h20);
        rd_chk("fall_vs_w1c", 3'd3, 32'h0, 32'h20);

        // Mask width, unmapped reads, mask gating of a pending bit
        wr(3'd2, 32'hFFFF_FFFF);
        rd_chk("mask_rd", 3'd2, 32'h3FFF, 32'h3FFF);
        rd_chk("addr6_rd", 3'd6, 32'h0, 32'h0);
        rd_chk("addr4_rd", 3'd4, 32'h0, 32'h0);
        check("mask_irq_on", 32'(irq_a), 32'h1);
        wr(3'd2, 32'h0);
        check("mask_irq_off", 32'(irq_a), 32'h0);
        rd_chk("mask_cap_kept", 3'd3, 32'h0, 32'h20);
        wr(3'd2, 32'h20);
        check("unmask_irq", 32'(irq_a), 32'h1);

        // Reset mid-stream takes effect before the next clock edge
        wr(3'd0, 32'h111);
        wr(3'd1, 32'h00F);
        reset = 1'b1;
        #1;
        check("mid_rst_out", 32'(out_a), 32'h2A5);
        check("mid_rst_oe",  32'(oe_a),  32'h3FFF);
        check("mid_rst_irq", 32'(irq_a), 32'h0);
        rd_chk("mid_rst_mask", 3'd2, 32'h0, 32'h0);
        rd_chk("mid_rst_cap",  3'd3, 32'h0, 32'h0);
        tick();
        reset = 1'b0;

        // Randomised traffic; the compare process checks every cycle
        for (int c = 0; c < 2000; c++) begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = in_port ^ 14'(1 << $urandom_range(0, 13));
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
